// File: rtl/pmod_key_reader_if.sv
// rtl/pmod_key_reader_if.sv - key event valid/ready handshake bundle
// Ports (modport master = event producer, slave = event consumer):
//   evt_valid  event available
//   evt_ready  consumer accepts event when evt_valid && evt_ready
//   evt_key    key index of the event
//   evt_press  1 = press, 0 = release
interface pmod_key_reader_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] evt_key;
    logic       evt_press;

    modport master (
        output evt_valid,
        output evt_key,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_key,
        input  evt_press,
        output evt_ready
    );
endinterface

// File: rtl/pmod_key_reader.sv
// rtl/pmod_key_reader.sv - debounced active-low PMOD key reader with press/release events
// Purpose: synchronise and debounce N_KEYS active-low keys, expose the debounced level
//   vector and report every accepted press/release on a valid/ready event channel.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   key_n      raw keys, active-low, asynchronous
//   key_state  debounced level, 1 = pressed
//   evt        event channel (pmod_key_reader_if.master)
//   evt_ovf    sticky lost-event flag
//   ovf_clr    single-cycle clear of evt_ovf
//   led        (only with PMOD_KEY_LED_ECHO_EN) active-low echo of key_state
// Configuration macro: PMOD_KEY_LED_ECHO_EN adds the led port.
module pmod_key_reader #(
    parameter int N_KEYS    = 16,
    parameter int TICK_DIV  = 2100,
    parameter int DEB_TICKS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_KEYS-1:0]     key_n,
    output logic [N_KEYS-1:0]     key_state,
    pmod_key_reader_if.master     evt,
    output logic                  evt_ovf,
    input  logic                  ovf_clr
`ifdef PMOD_KEY_LED_ECHO_EN
    ,
    output logic [N_KEYS-1:0]     led
`endif
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

    logic [N_KEYS-1:0] sync1_q;
    logic [N_KEYS-1:0] sync2_q;
    logic [N_KEYS-1:0] s;

    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;

    logic [N_KEYS-1:0] key_state_q, key_state_d;
    logic [CW-1:0]     cnt_q [N_KEYS];
    logic [CW-1:0]     cnt_d [N_KEYS];
    logic [N_KEYS-1:0] trans;

    logic [N_KEYS-1:0] pend_q, pend_d;
    logic [N_KEYS-1:0] pend_dir_q, pend_dir_d;

    logic              evt_valid_q, evt_valid_d;
    logic [3:0]        evt_key_q, evt_key_d;
    logic              evt_press_q, evt_press_d;
    logic              ovf_q, ovf_d;

    logic [N_KEYS-1:0] sel_oh;
    logic [3:0]        sel_idx;
    logic              load;
    logic              ovf_hit;

    always_comb begin
        s          = ~sync2_q;
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

        // Lowest pending key: isolate the least significant set bit.
        sel_oh  = pend_q & (~pend_q + N_KEYS'(1));
        sel_idx = 4'd0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_idx = 4'(i);
            end
        end
        load = (|pend_q) && (!evt_valid_q || evt.evt_ready);

        evt_valid_d = evt_valid_q;
        evt_key_d   = evt_key_q;
        evt_press_d = evt_press_q;
        pend_d      = pend_q;
        pend_dir_d  = pend_dir_q;

        if (load) begin
            evt_valid_d = 1'b1;
            evt_key_d   = sel_idx;
            evt_press_d = |(pend_dir_q & sel_oh);
            pend_d      = pend_q & ~sel_oh;
        end else if (evt.evt_ready) begin
            evt_valid_d = 1'b0;
        end

        key_state_d = key_state_q;
        trans       = '0;
        ovf_hit     = 1'b0;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (s[i] == key_state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CW'(DEB_TICKS - 1)) begin
                    key_state_d[i] = s[i];
                    cnt_d[i]       = '0;
                    trans[i]       = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
            // pend_d already has the key being loaded this cycle cleared, so a
            // transition on that key starts a fresh pending event instead of
            // cancelling the one just issued.
            if (trans[i]) begin
                if (pend_d[i]) begin
                    pend_d[i] = 1'b0;
                    ovf_hit   = 1'b1;
                end else begin
                    pend_d[i]     = 1'b1;
                    pend_dir_d[i] = s[i];
                end
            end
        end

        // A new overflow outranks a simultaneous clear.
        ovf_d = (ovf_q && !ovf_clr) || ovf_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            tick_cnt_q  <= '0;
            key_state_q <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q      <= '0;
            pend_dir_q  <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= 4'd0;
            evt_press_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            sync1_q     <= key_n;
            sync2_q     <= sync1_q;
            tick_cnt_q  <= tick_cnt_d;
            key_state_q <= key_state_d;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q      <= pend_d;
            pend_dir_q  <= pend_dir_d;
            evt_valid_q <= evt_valid_d;
            evt_key_q   <= evt_key_d;
            evt_press_q <= evt_press_d;
            ovf_q       <= ovf_d;
        end
    end

    assign key_state     = key_state_q;
    assign evt.evt_valid = evt_valid_q;
    assign evt.evt_key   = evt_key_q;
    assign evt.evt_press = evt_press_q;
    assign evt_ovf       = ovf_q;

`ifdef PMOD_KEY_LED_ECHO_EN
    assign led = ~key_state_q;
`endif

endmodule

// File: tb/tb_pmod_key_reader.sv
// tb/tb_pmod_key_reader.sv - self-checking bench for pmod_key_reader
module tb_pmod_key_reader;

    localparam int N_KEYS    = 16;
    localparam int TICK_DIV  = 4;
    localparam int DEB_TICKS = 3;
    localparam int DEB_BUDGET = 2 + DEB_TICKS * TICK_DIV + 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_KEYS-1:0] key_n;
    logic [N_KEYS-1:0] key_state;
    logic              evt_ovf;
    logic              ovf_clr;
`ifdef PMOD_KEY_LED_ECHO_EN
    logic [N_KEYS-1:0] led;
`endif

    pmod_key_reader_if evt_if ();

    pmod_key_reader #(
        .N_KEYS    (N_KEYS),
        .TICK_DIV  (TICK_DIV),
        .DEB_TICKS (DEB_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .key_state (key_state),
        .evt       (evt_if.master),
        .evt_ovf   (evt_ovf),
        .ovf_clr   (ovf_clr)
`ifdef PMOD_KEY_LED_ECHO_EN
        ,
        .led       (led)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_evt  = 0;
    logic [4:0] sb_q [$];
    int acc_cyc [$];
    logic [4:0] mon_e;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every accepted event must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
            n_evt++;
            acc_cyc.push_back(cyc);
            if (sb_q.size() == 0) begin
                check("evt_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("evt_key", 32'(evt_if.evt_key), 32'(mon_e[3:0]));
                check("evt_press", 32'(evt_if.evt_press), 32'(mon_e[4]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_evt(input int key, input logic press);
        sb_q.push_back({press, 4'(key)});
    endtask

    task automatic wait_key(input int idx, input logic lvl, input int budget);
        int k = 0;
        while (key_state[idx] !== lvl && k < budget) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("key_state[%0d]", idx), 32'(key_state[idx]), 32'(lvl));
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            step(1);
            k++;
        end
        check("sb_drain", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (evt_if.evt_valid !== 1'b1 && k < budget) begin
            step(1);
            k++;
        end
        check("evt_valid_rise", 32'(evt_if.evt_valid), 32'd1);
    endtask

    initial begin
        int n0;
        rst              = 1'b1;
        key_n            = '1;
        ovf_clr          = 1'b0;
        evt_if.evt_ready = 1'b1;

        // Reset state and quiet idle.
        step(3);
        check("rst_key_state", 32'(key_state), 32'd0);
        check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
        check("rst_evt_key", 32'(evt_if.evt_key), 32'd0);
        check("rst_evt_press", 32'(evt_if.evt_press), 32'd0);
        check("rst_evt_ovf", 32'(evt_ovf), 32'd0);
        rst = 1'b0;
        step(100);
        check("idle_events", 32'(n_evt), 32'd0);

        // Single press and release of key 5.
        key_n[5] = 1'b0;
        expect_evt(5, 1'b1);
        wait_key(5, 1'b1, DEB_BUDGET);
        wait_drain(10);
        step(1);
        key_n[5] = 1'b1;
        expect_evt(5, 1'b0);
        wait_key(5, 1'b0, DEB_BUDGET);
        wait_drain(10);

        // Key 2 bouncing every 3 cycles never holds for 3 consecutive ticks.
        n0 = n_evt;
        for (int j = 0; j < 14; j++) begin
            key_n[2] = (j % 2 == 1);
            step(3);
        end
        check("bounce_no_evt", 32'(n_evt), 32'(n0));
        check("bounce_state", 32'(key_state[2]), 32'd0);
        key_n[2] = 1'b0;
        expect_evt(2, 1'b1);
        wait_key(2, 1'b1, DEB_BUDGET);
        wait_drain(10);
        step(1);
        key_n[2] = 1'b1;
        expect_evt(2, 1'b0);
        wait_key(2, 1'b0, DEB_BUDGET);
        wait_drain(10);

        // Simultaneous presses of 9 and 3 under backpressure.
        step(1);
        evt_if.evt_ready = 1'b0;
        key_n[9] = 1'b0;
        key_n[3] = 1'b0;
        expect_evt(3, 1'b1);
        expect_evt(9, 1'b1);
        wait_valid(25);
        step(5);
        check("hold_evt_key", 32'(evt_if.evt_key), 32'd3);
        check("hold_evt_valid", 32'(evt_if.evt_valid), 32'd1);
        n0 = acc_cyc.size();
        evt_if.evt_ready = 1'b1;
        wait_drain(10);
        if (acc_cyc.size() >= n0 + 2)
            check("b2b_gap", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'd1);
        else
            check("b2b_count", 32'(acc_cyc.size()), 32'(n0 + 2));
        key_n[9] = 1'b1;
        key_n[3] = 1'b1;
        expect_evt(3, 1'b0);
        expect_evt(9, 1'b0);
        wait_key(3, 1'b0, DEB_BUDGET);
        wait_drain(10);

        // Key 1 occupies the output; key 7 press+release cancels and overflows.
        step(1);
        evt_if.evt_ready = 1'b0;
        key_n[1] = 1'b0;
        expect_evt(1, 1'b1);
        wait_valid(25);
        key_n[7] = 1'b0;
        wait_key(7, 1'b1, DEB_BUDGET);
        step(1);
        key_n[7] = 1'b1;
        wait_key(7, 1'b0, DEB_BUDGET);
        step(1);
        check("ovf_set", 32'(evt_ovf), 32'd1);
        check("ovf_hold_key", 32'(evt_if.evt_key), 32'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check("ovf_clr", 32'(evt_ovf), 32'd0);
        evt_if.evt_ready = 1'b1;
        wait_drain(10);
        key_n[1] = 1'b1;
        expect_evt(1, 1'b0);
        wait_key(1, 1'b0, DEB_BUDGET);
        wait_drain(10);

        // Reset while key 0 is held with an event pending.
        step(1);
        evt_if.evt_ready = 1'b0;
        key_n[0] = 1'b0;
        wait_valid(25);
        rst = 1'b1;
        step(1);
        check("mid_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        check("mid_rst_state", 32'(key_state), 32'd0);
        check("mid_rst_press", 32'(evt_if.evt_press), 32'd0);
        check("mid_rst_ovf", 32'(evt_ovf), 32'd0);
        step(2);
        rst = 1'b0;
        evt_if.evt_ready = 1'b1;
        expect_evt(0, 1'b1);
        wait_key(0, 1'b1, DEB_BUDGET + 4);
        wait_drain(10);
        step(1);
        key_n[0] = 1'b1;
        expect_evt(0, 1'b0);
        wait_key(0, 1'b0, DEB_BUDGET);
        wait_drain(10);

        step(5);
        check("total_events", 32'(n_evt), 32'd12);
`ifdef PMOD_KEY_LED_ECHO_EN
        check("led_echo", 32'(led), 32'(~key_state));
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
